ssd_scan_controller: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one `sevenSegmentDigit` decoder. It captures a packed multi-digit BCD value through a load handshake and holds it in a shadow register. The new value is applied only at a frame boundary, so a displayed number never tears mid-scan. Each digit is then presented in turn on the shared `bcd`/`blank` lines with its anode enabled.

---
 rtl/ssd_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_ssd_scan_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
// -------------------
// Time-multiplexed scan controller for a bank of common-anode seven-segment
// digits that share one BCD decoder. A packed BCD value is captured into a
// shadow register on a load strobe. That value moves to the display register
// only at a frame boundary, so a number never tears mid-scan. Each digit is
// then presented in turn on bcd/blank with its anode driven low.
//
// Optional feature: define SSD_LZ_BLANK_EN to enable leading-zero
// suppression. When it is undefined, every valid digit is shown.
//
// Handshake: load is a fire-and-forget single-cycle strobe and has no ready.
// The shadow always takes value on a load, and the latest load before a
// frame wrap wins. A load on the wrap cycle itself goes straight to the
// display.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   value       packed BCD, digit i = value[4i+3:4i], digit 0 least significant
//   load        capture strobe for value
//   blank_all   force blank while high (scanning continues)
//   bcd         current digit to the decoder
//   blank       decoder blank control
//   anode       active-low digit enables
//   pending     shadow holds a value not yet displayed
//   frame_done  one-cycle pulse on the wrap from digit NUM_DIGITS-1 to 0
module ssd_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_all,
  output logic [3:0]              bcd,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W  = 4 * NUM_DIGITS;

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap;
  logic                  lz_blank;

  assign tick = (pcnt_q == PCNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Scan counters, shadow and display register update.
  always_comb begin
    pcnt_d       = pcnt_q + PCNT_W'(1);
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    frame_done_d = wrap;

    if (tick) begin
      pcnt_d = '0;
      idx_d  = wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      shadow_d = value;
    end

    if (wrap) begin
      // A load landing on the wrap cycle bypasses the shadow so that it is
      // shown from the very next digit 0 and never reports pending.
      if (load) begin
        disp_d    = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Outputs are registered and look at the next-state index/display so that
  // the pins change on the same edge as the scan position.
  always_comb begin
    bcd_d    = 4'd0;
    anode_d  = '1;
    lz_blank = 1'b0;

    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_d == IDX_W'(j)) begin
        bcd_d      = disp_d[4*j +: 4];
        anode_d[j] = 1'b0;
      end
    end

`ifdef SSD_LZ_BLANK_EN
    // Digit i>=1 is blank when it and every more significant digit are 0.
    // Digit 0 is never suppressed so that an all-zero value still shows "0".
    if (idx_d != '0) begin
      lz_blank = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if ((IDX_W'(j) >= idx_d) && (disp_d[4*j +: 4] != 4'd0)) begin
          lz_blank = 1'b0;
        end
      end
    end
`else
    lz_blank = 1'b0;
`endif

    blank_d = blank_all || (bcd_d > 4'd9) || lz_blank;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      bcd_q        <= 4'd0;
      blank_q      <= 1'b1;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      bcd_q        <= bcd_d;
      blank_q      <= blank_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign blank      = blank_q;
  assign anode      = anode_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller with NUM_DIGITS=4 and REFRESH_DIV=4.
// Edge numbers in the comments count rising edges after reset release (E1 is
// the first one). Outputs are sampled 1 time unit after each rising edge.
module tb_ssd_scan_controller;

  logic        clock;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_all;
  logic [3:0]  bcd;
  logic        blank;
  logic [3:0]  anode;
  logic        pending;
  logic        frame_done;

  int total;
  int bad;

`ifdef SSD_LZ_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  ssd_scan_controller #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_all (blank_all),
    .bcd       (bcd),
    .blank     (blank),
    .anode     (anode),
    .pending   (pending),
    .frame_done(frame_done)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    value     = 16'h0;
    load      = 1'b0;
    blank_all = 1'b0;

    // Reset held 3 cycles
    step(3);
    check("rst_anode", 16'(anode), 16'hF);
    check("rst_blank", 16'(blank), 16'h1);
    check("rst_bcd", 16'(bcd), 16'h0);
    check("rst_pending", 16'(pending), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);

    reset = 1'b0;
    step(1); // E1
    check("e1_anode", 16'(anode), 16'hE);
    check("e1_bcd", 16'(bcd), 16'h0);
    check("e1_blank", 16'(blank), 16'h0);
    step(2); // E3: still digit 0 (pcnt started at 0 during reset)
    check("e3_anode", 16'(anode), 16'hE);
    step(1); // E4
    check("e4_anode", 16'(anode), 16'hD);
    step(4); // E8
    check("e8_anode", 16'(anode), 16'hB);
    step(4); // E12
    check("e12_anode", 16'(anode), 16'h7);
    step(3); // E15
    check("e15_fd", 16'(frame_done), 16'h0);
    step(1); // E16 frame wrap
    check("e16_fd", 16'(frame_done), 16'h1);
    check("e16_anode", 16'(anode), 16'hE);
    step(1); // E17
    check("e17_fd", 16'(frame_done), 16'h0);

    // Load mid-frame: held in shadow until the wrap at E32
    do_load(16'h1234); // E18
    check("ld_pending", 16'(pending), 16'h1);
    check("ld_bcd_old", 16'(bcd), 16'h0);
    step(13); // E31
    check("e31_pending", 16'(pending), 16'h1);
    step(1); // E32 wrap
    check("e32_pending", 16'(pending), 16'h0);
    check("e32_bcd", 16'(bcd), 16'h4);
    check("e32_fd", 16'(frame_done), 16'h1);
    step(4); // E36
    check("e36_bcd", 16'(bcd), 16'h3);
    step(4); // E40
    check("e40_bcd", 16'(bcd), 16'h2);
    step(4); // E44
    check("e44_bcd", 16'(bcd), 16'h1);
    check("e44_blank", 16'(blank), 16'h0);
    step(4); // E48
    check("e48_bcd", 16'(bcd), 16'h4);

    // Two loads before the wrap: only the latest is shown
    step(1);           // E49
    do_load(16'h1111); // E50
    check("dbl_pending", 16'(pending), 16'h1);
    step(2);           // E52
    do_load(16'h5678); // E53
    check("dbl_bcd_old", 16'(bcd), 16'h3);
    check("dbl_pending2", 16'(pending), 16'h1);
    step(11); // E64 wrap
    check("e64_bcd", 16'(bcd), 16'h8);
    check("e64_pending", 16'(pending), 16'h0);
    step(4);
    check("e68_bcd", 16'(bcd), 16'h7);
    step(4);
    check("e72_bcd", 16'(bcd), 16'h6);
    step(4);
    check("e76_bcd", 16'(bcd), 16'h5);

    // Load on the exact wrap cycle goes straight to the display
    step(3);           // E79
    do_load(16'h9999); // E80 wrap
    check("wl_bcd", 16'(bcd), 16'h9);
    check("wl_pending", 16'(pending), 16'h0);
    check("wl_fd", 16'(frame_done), 16'h1);
    check("wl_anode", 16'(anode), 16'hE);

    // Out-of-range digit and leading zeros
    do_load(16'h00A5); // E81
    check("a5_pending", 16'(pending), 16'h1);
    check("a5_bcd_old", 16'(bcd), 16'h9);
    step(15); // E96 wrap
    check("e96_bcd", 16'(bcd), 16'h5);
    check("e96_blank", 16'(blank), 16'h0);
    step(4); // E100
    check("e100_bcd", 16'(bcd), 16'hA);
    check("e100_blank", 16'(blank), 16'h1);
    check("e100_anode", 16'(anode), 16'hD);
    step(4); // E104
    check("e104_bcd", 16'(bcd), 16'h0);
    check("e104_blank", 16'(blank), 16'(LZ));
    step(4); // E108
    check("e108_anode", 16'(anode), 16'h7);
    check("e108_blank", 16'(blank), 16'(LZ));

    // blank_all forces blank while the scan keeps running
    blank_all = 1'b1;
    step(1); // E109
    check("ba_blank", 16'(blank), 16'h1);
    check("ba_anode", 16'(anode), 16'h7);
    step(3); // E112
    check("ba_blank_d0", 16'(blank), 16'h1);
    check("ba_anode_d0", 16'(anode), 16'hE);
    check("ba_bcd_d0", 16'(bcd), 16'h5);
    blank_all = 1'b0;
    step(1); // E113
    check("ba_off_blank", 16'(blank), 16'h0);

    // Reset while a value is pending
    do_load(16'h4321); // E114
    check("rp_pending", 16'(pending), 16'h1);
    step(2);
    reset = 1'b1;
    step(1);
    check("rp_anode", 16'(anode), 16'hF);
    check("rp_bcd", 16'(bcd), 16'h0);
    check("rp_blank", 16'(blank), 16'h1);
    check("rp_pending0", 16'(pending), 16'h0);
    check("rp_fd", 16'(frame_done), 16'h0);
    step(2);
    reset = 1'b0;
    step(1); // R1
    check("r1_anode", 16'(anode), 16'hE);
    check("r1_bcd", 16'(bcd), 16'h0);
    check("r1_blank", 16'(blank), 16'h0);
    check("r1_pending", 16'(pending), 16'h0);
    step(3); // R4
    check("r4_anode", 16'(anode), 16'hD);
    check("r4_blank", 16'(blank), 16'(LZ));
    step(12); // R16 wrap: discarded value must not appear
    check("r16_fd", 16'(frame_done), 16'h1);
    check("r16_bcd", 16'(bcd), 16'h0);
    check("r16_pending", 16'(pending), 16'h0);
    step(4); // R20
    check("r20_bcd", 16'(bcd), 16'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
